// File: rtl/vga_timing_gen.sv
// Pixel-stream timing source: free-running h/v counters with blanking, sync and frame-start flags.
// Every flag is decoded from the next-count value and registered with the counts, so all outputs describe the same pixel.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 1024,
  parameter int   H_FP        = 24,
  parameter int   H_SYNC      = 136,
  parameter int   H_BP        = 160,
  parameter int   V_VISIBLE   = 768,
  parameter int   V_FP        = 3,
  parameter int   V_SYNC      = 6,
  parameter int   V_BP        = 29,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;
  logic        hblnk_nxt;
  logic        vblnk_nxt;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        frame_start_nxt;

  always_comb begin
    hcount_nxt = hcount_out + 11'd1;
    vcount_nxt = vcount_out;
    if (hcount_out == H_LAST) begin
      hcount_nxt = '0;
      if (vcount_out == V_LAST) vcount_nxt = '0;
      else                      vcount_nxt = vcount_out + 11'd1;
    end
  end

  // Sync decode deliberately ignores blanking; the porches keep it inside the blanked region.
  always_comb begin
    hblnk_nxt       = (hcount_nxt >= H_VIS);
    vblnk_nxt       = (vcount_nxt >= V_VIS);
    hsync_nxt       = ((hcount_nxt >= HS_START) && (hcount_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_nxt       = ((vcount_nxt >= VS_START) && (vcount_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_start_nxt = (hcount_nxt == 11'd0) && (vcount_nxt == 11'd0);
  end

  // Reset parks at (0,0) with frame_start low, so the first pulse comes one full frame later.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      hsync_out   <= ~SYNC_ACTIVE;
      vsync_out   <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      hcount_out  <= hcount_nxt;
      vcount_out  <= vcount_nxt;
      hblnk_out   <= hblnk_nxt;
      vblnk_out   <= vblnk_nxt;
      hsync_out   <= hsync_nxt;
      vsync_out   <= vsync_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a shrunken-geometry instance for frame-level behaviour.
// Expected outputs come from elapsed-cycle arithmetic since the last reset.
module tb_vga_timing_gen;

  // Small geometry: H_TOTAL=32, V_TOTAL=19, frame=608 cycles.
  localparam int B_HV = 20, B_HFP = 3, B_HS = 5, B_HBP = 4;
  localparam int B_VV = 12, B_VFP = 2, B_VS = 3, B_VBP = 2;
  localparam int A_HT = 1344, A_VT = 806;
  localparam int B_HT = 32,   B_VT = 19;
  localparam int BX = 6, BW = 4, BY = 3, BH = 5;

  logic pclk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  logic [10:0] hc_a, vc_a, hc_b, vc_b;
  logic hb_a, vb_a, hs_a, vs_a, fs_a;
  logic hb_b, vb_b, hs_b, vs_b, fs_b;

  int checks = 0;
  int errors = 0;
  longint n_a = 0;
  longint n_b = 0;

  vga_timing_gen dut_a (
    .pclk(pclk), .rst_n(rst_a),
    .hcount_out(hc_a), .vcount_out(vc_a),
    .hblnk_out(hb_a), .vblnk_out(vb_a),
    .hsync_out(hs_a), .vsync_out(vs_a),
    .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .SYNC_ACTIVE(1'b0)
  ) dut_b (
    .pclk(pclk), .rst_n(rst_b),
    .hcount_out(hc_b), .vcount_out(vc_b),
    .hblnk_out(hb_b), .vblnk_out(vb_b),
    .hsync_out(hs_b), .vsync_out(vs_b),
    .frame_start(fs_b)
  );

  wire [26:0] obs_a = {hc_a, vc_a, hb_a, vb_a, hs_a, vs_a, fs_a};
  wire [26:0] obs_b = {hc_b, vc_b, hb_b, vb_b, hs_b, vs_b, fs_b};

  always #5 pclk = ~pclk;

  // Downstream draw stage: one register on counts and on a block-pixel flag gated by blanking.
  logic [10:0] d_h, d_v;
  logic        d_pix;
  always_ff @(posedge pclk) begin
    d_h   <= hc_b;
    d_v   <= vc_b;
    d_pix <= (hc_b >= 11'(BX)) && (hc_b < 11'(BX + BW)) &&
             (vc_b >= 11'(BY)) && (vc_b < 11'(BY + BH)) && !hb_b && !vb_b;
  end

  // Expected output vector after n counting edges since reset (n=0 means in/just out of reset).
  function automatic logic [26:0] model(longint n, int hv, int hfp, int hsw, int hbp,
                                        int vv, int vfp, int vsw, int vbp);
    int ht, vt, h, v;
    longint t;
    logic hb, vb, hs, vs, fs;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    t  = n % (longint'(ht) * vt);
    h  = int'(t % ht);
    v  = int'(t / ht);
    hb = (h >= hv);
    vb = (v >= vv);
    hs = !((h >= hv + hfp) && (h < hv + hfp + hsw));
    vs = !((v >= vv + vfp) && (v < vv + vfp + vsw));
    fs = (t == 0) && (n != 0);
    return {11'(h), 11'(v), hb, vb, hs, vs, fs};
  endfunction

  function automatic logic [26:0] exp_a(longint n);
    return model(n, 1024, 24, 136, 160, 768, 3, 6, 29);
  endfunction

  function automatic logic [26:0] exp_b(longint n);
    return model(n, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP);
  endfunction

  task automatic tick();
    @(posedge pclk);
    n_a = rst_a ? n_a + 1 : 0;
    n_b = rst_b ? n_b + 1 : 0;
    #1;
  endtask

  task automatic test_reset();
    int k;
    k = $urandom_range(2, 6);
    rst_a = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < k; i++) begin
      tick();
      checks += 2;
      if (obs_a !== exp_a(n_a)) begin errors++; $display("FAIL reset_hold_a got %h want %h", obs_a, exp_a(n_a)); end
      if (obs_b !== exp_b(n_b)) begin errors++; $display("FAIL reset_hold_b got %h want %h", obs_b, exp_b(n_b)); end
    end
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
    checks += 3;
    if (hc_a !== 11'd1 || vc_a !== 11'd0) begin errors++; $display("FAIL release_count got h=%0d v=%0d want h=1 v=0", hc_a, vc_a); end
    if ({hb_a, vb_a, hs_a, vs_a, fs_a} !== 5'b00110) begin errors++; $display("FAIL release_flags got %b want 00110", {hb_a, vb_a, hs_a, vs_a, fs_a}); end
    if (obs_b !== exp_b(n_b)) begin errors++; $display("FAIL release_b got %h want %h", obs_b, exp_b(n_b)); end
  endtask

  task automatic test_line();
    int hb_cnt, hs_cnt, guard;
    logic [10:0] v_prev;
    guard = 0;
    while (hc_a !== 11'd0 && guard < 1400) begin
      tick();
      guard++;
      checks++;
      if (obs_a !== exp_a(n_a)) begin errors++; $display("FAIL line_seek got %h want %h", obs_a, exp_a(n_a)); end
    end
    checks++;
    if (hc_a !== 11'd0) begin errors++; $display("FAIL line_wrap_timeout got h=%0d want 0", hc_a); end
    hb_cnt = int'(hb_a);
    hs_cnt = int'(!hs_a);
    v_prev = vc_a;
    for (int i = 1; i < A_HT; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_a(n_a)) begin errors++; $display("FAIL line_pixel got %h want %h", obs_a, exp_a(n_a)); end
      hb_cnt += int'(hb_a);
      hs_cnt += int'(!hs_a);
    end
    tick();
    checks += 4;
    if (hb_cnt != 320) begin errors++; $display("FAIL hblnk_width got %0d want 320", hb_cnt); end
    if (hs_cnt != 136) begin errors++; $display("FAIL hsync_width got %0d want 136", hs_cnt); end
    if (hc_a !== 11'd0) begin errors++; $display("FAIL line_wrap got h=%0d want 0", hc_a); end
    if (vc_a !== v_prev + 11'd1) begin errors++; $display("FAIL vstep got v=%0d want %0d", vc_a, v_prev + 11'd1); end
  endtask

  task automatic test_frame();
    int guard, vb_cnt, vs_cnt;
    guard = 0;
    while (!(hc_b == 11'(B_HT - 1) && vc_b == 11'(B_VT - 1)) && guard < 700) begin
      tick();
      guard++;
      checks++;
      if (obs_b !== exp_b(n_b)) begin errors++; $display("FAIL frame_seek got %h want %h", obs_b, exp_b(n_b)); end
    end
    tick();
    checks++;
    if (hc_b !== 11'd0 || vc_b !== 11'd0 || fs_b !== 1'b1) begin
      errors++; $display("FAIL frame_wrap got h=%0d v=%0d fs=%b want 0 0 1", hc_b, vc_b, fs_b);
    end
    vb_cnt = int'(vb_b);
    vs_cnt = int'(!vs_b);
    tick();
    checks++;
    if (fs_b !== 1'b0 || hc_b !== 11'd1) begin errors++; $display("FAIL frame_pulse_len got fs=%b h=%0d want 0 1", fs_b, hc_b); end
    vb_cnt += int'(vb_b);
    vs_cnt += int'(!vs_b);
    for (int i = 2; i < B_HT * B_VT; i++) begin
      tick();
      checks++;
      if (obs_b !== exp_b(n_b)) begin errors++; $display("FAIL frame_pixel got %h want %h", obs_b, exp_b(n_b)); end
      vb_cnt += int'(vb_b);
      vs_cnt += int'(!vs_b);
    end
    checks += 2;
    if (vb_cnt != (B_VT - B_VV) * B_HT) begin errors++; $display("FAIL vblnk_cycles got %0d want %0d", vb_cnt, (B_VT - B_VV) * B_HT); end
    if (vs_cnt != B_VS * B_HT) begin errors++; $display("FAIL vsync_cycles got %0d want %0d", vs_cnt, B_VS * B_HT); end
  endtask

  task automatic test_period();
    longint cyc, last_hs, last_fs;
    int n_hs, n_fs;
    logic hs_prev;
    cyc = 0; last_hs = -1; last_fs = -1; n_hs = 0; n_fs = 0;
    hs_prev = hs_a;
    for (int i = 0; i < 3 * A_HT + 50; i++) begin
      tick();
      cyc++;
      checks += 2;
      if (obs_a !== exp_a(n_a)) begin errors++; $display("FAIL period_a got %h want %h", obs_a, exp_a(n_a)); end
      if (obs_b !== exp_b(n_b)) begin errors++; $display("FAIL period_b got %h want %h", obs_b, exp_b(n_b)); end
      if (hs_prev === 1'b1 && hs_a === 1'b0) begin
        if (last_hs >= 0) begin
          checks++; n_hs++;
          if (cyc - last_hs != A_HT) begin errors++; $display("FAIL hsync_period got %0d want %0d", cyc - last_hs, A_HT); end
        end
        last_hs = cyc;
      end
      hs_prev = hs_a;
      if (fs_b === 1'b1) begin
        if (last_fs >= 0) begin
          checks++; n_fs++;
          if (cyc - last_fs != B_HT * B_VT) begin errors++; $display("FAIL frame_period got %0d want %0d", cyc - last_fs, B_HT * B_VT); end
        end
        last_fs = cyc;
      end
    end
    checks += 2;
    if (n_hs < 2) begin errors++; $display("FAIL hsync_edges got %0d want >=2", n_hs); end
    if (n_fs < 2) begin errors++; $display("FAIL frame_pulses got %0d want >=2", n_fs); end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while (!(hc_b == 11'd25 && vc_b == 11'd15) && guard < 700) begin
      tick();
      guard++;
    end
    checks++;
    if (hs_b !== 1'b0 || vs_b !== 1'b0) begin errors++; $display("FAIL mid_syncs_active got hs=%b vs=%b want 0 0", hs_b, vs_b); end
    rst_b = 1'b0;
    tick();
    checks++;
    if ({hc_b, vc_b, hb_b, vb_b, hs_b, vs_b, fs_b} !== {11'd0, 11'd0, 5'b00110}) begin
      errors++; $display("FAIL mid_reset got h=%0d v=%0d flags=%b want 0 0 00110", hc_b, vc_b, {hb_b, vb_b, hs_b, vs_b, fs_b});
    end
    rst_b = 1'b1;
    tick();
    checks++;
    if (hc_b !== 11'd1 || vc_b !== 11'd0) begin errors++; $display("FAIL mid_resume got h=%0d v=%0d want 1 0", hc_b, vc_b); end
  endtask

  task automatic test_random_resets();
    int run, hold;
    for (int it = 0; it < 8; it++) begin
      run = $urandom_range(1, 700);
      for (int i = 0; i < run; i++) begin
        tick();
        checks += 2;
        if (obs_a !== exp_a(n_a)) begin errors++; $display("FAIL rnd_run_a got %h want %h", obs_a, exp_a(n_a)); end
        if (obs_b !== exp_b(n_b)) begin errors++; $display("FAIL rnd_run_b got %h want %h", obs_b, exp_b(n_b)); end
      end
      rst_a = $urandom_range(0, 1) ? 1'b0 : 1'b1;
      rst_b = 1'b0;
      hold = $urandom_range(1, 3);
      for (int i = 0; i < hold; i++) begin
        tick();
        checks += 2;
        if (obs_a !== exp_a(n_a)) begin errors++; $display("FAIL rnd_rst_a got %h want %h", obs_a, exp_a(n_a)); end
        if (obs_b !== exp_b(n_b)) begin errors++; $display("FAIL rnd_rst_b got %h want %h", obs_b, exp_b(n_b)); end
      end
      rst_a = 1'b1; rst_b = 1'b1;
    end
  endtask

  task automatic test_draw_alignment();
    logic [26:0] e;
    int ph, pv, pix_cnt;
    logic want;
    pix_cnt = 0;
    repeat (2) tick();
    for (int i = 0; i < B_HT * B_VT; i++) begin
      tick();
      e    = exp_b(n_b - 1);
      ph   = int'(e[26:16]);
      pv   = int'(e[15:5]);
      want = (ph >= BX) && (ph < BX + BW) && (pv >= BY) && (pv < BY + BH);
      checks++;
      if (d_pix !== want || d_h !== 11'(ph) || d_v !== 11'(pv)) begin
        errors++; $display("FAIL draw_align got pix=%b h=%0d v=%0d want pix=%b h=%0d v=%0d", d_pix, d_h, d_v, want, ph, pv);
      end
      pix_cnt += int'(d_pix === 1'b1);
    end
    checks++;
    if (pix_cnt != BW * BH) begin errors++; $display("FAIL draw_pixels got %0d want %0d", pix_cnt, BW * BH); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_period();
    test_mid_reset();
    test_random_resets();
    test_draw_alignment();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the pixel-stream interface consumed by the rectangle/board drawing stages.
- Generates hcount/vcount, blanking and sync for 1024x768 @ 60 Hz from the 65 MHz pixel clock.
- Its outputs feed the first draw stage directly. All outputs are registered and mutually aligned on the same pclk edge.
- Also produces a one-cycle frame_start pulse so game logic can update board state once per frame.

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch; H_TOTAL = 1344
- V_VISIBLE, 768, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch; V_TOTAL = 806
- SYNC_ACTIVE, 1'b0, output level of hsync/vsync when asserted (VGA 1024x768 uses negative sync)

Ports:
- pclk  input  1  pixel clock, 65 MHz, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- hcount_out  output  11  current pixel column, 0..H_TOTAL-1
- vcount_out  output  11  current line, 0..V_TOTAL-1
- hblnk_out  output  1  high when hcount_out >= H_VISIBLE
- vblnk_out  output  1  high when vcount_out >= V_VISIBLE
- hsync_out  output  1  SYNC_ACTIVE when H_VISIBLE+H_FP <= hcount_out < H_VISIBLE+H_FP+H_SYNC, else ~SYNC_ACTIVE
- vsync_out  output  1  SYNC_ACTIVE when V_VISIBLE+V_FP <= vcount_out < V_VISIBLE+V_FP+V_SYNC, else ~SYNC_ACTIVE
- frame_start  output  1  one-cycle pulse, high exactly when hcount_out==0 and vcount_out==0

Behaviour:
- Reset, sampled on the pclk edge while rst_n==0:
  - hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0.
  - hsync_out=vsync_out=~SYNC_ACTIVE.
  - frame_start=0. The first pulse occurs at the first (0,0) reached after a full frame, not at reset release.
- Reset mid-frame: counters return to 0 on the next edge with rst_n==0. No partial sync pulse is held.
- First edge after rst_n goes high: hcount_out=1, vcount_out=0. Counting is free-running; there is no enable.
- Horizontal counter: hcount increments by 1 each pclk. At H_TOTAL-1 it wraps to 0.
- Vertical counter: vcount increments only on the cycle where hcount wraps (H_TOTAL-1 -> 0). At V_TOTAL-1 with an hcount wrap, vcount wraps to 0.
- Registered outputs: internal next-state hcount_nxt/vcount_nxt is computed combinationally. Blank, sync and frame_start are decoded from the *_nxt values and registered on the same edge as the counts.
  - Result: every output describes the same pixel, with zero skew between count and flags.
  - Latency from count to flags is 0 cycles, as seen at the ports.
- Blanking boundaries:
  - hblnk_out rises on hcount_out==1024 and falls on hcount_out==0.
  - vblnk_out rises on vcount_out==768 (for the whole line, all 1344 pixels) and falls on vcount_out==0.
- Sync boundaries (defaults):
  - hsync asserted for hcount 1048..1183, i.e. 136 cycles.
  - vsync asserted for vcount 771..776, i.e. 6 lines = 8064 cycles. vsync changes only at hcount==0.
- Sync independence: sync level is independent of blanking decode. Syncs lie entirely inside blanking for legal parameters.
- Widths:
  - Counters are 11 bits.
  - Parameter sums H_TOTAL and V_TOTAL must be <= 2047.
  - Comparisons are unsigned.
- Period: frame period is H_TOTAL*V_TOTAL = 1,083,264 pclk cycles.
- Downstream contract: draw stages add one pipeline register per stage to all of these signals, so alignment established here must be exact.

Test Plan:
1. Reset hold then release → outputs stay at reset values while rst_n=0. First post-release edge gives hcount=1, vcount=0, all blank=0, syncs=1 (inactive, negative polarity).
2. Run one line → hblnk=1 exactly for hcount 1024..1343 (320 cycles). hsync=0 exactly for hcount 1048..1183 (136 cycles). vcount steps 0→1 on the same edge hcount goes 1343→0.
3. Run full frame → vblnk=1 for vcount 767→768 transition onward through 805. vsync=0 for vcount 771..776. At (1343,805) the next edge gives (0,0) with frame_start=1 for exactly one cycle.
4. Measure period → frame_start pulses spaced exactly 1,083,264 cycles. hsync falling edges spaced exactly 1344 cycles.
5. Assert rst_n=0 for one cycle at hcount=1100, vcount=773 (both syncs active) → next edge gives counts 0, syncs=1, blanks=0, frame_start=0. Counting resumes from 1 after release.
6. Alignment check with a draw stage attached → a draw stage drawing a block at X=516, Y=675 shows its pixels at hcount_out 516..550, vcount_out 675..709 with no off-by-one columns or rows.
